// File: rtl/uart_pkg.sv
// Shared UART definitions: bit-timing defaults, frame width and FSM state encodings.
// Frame layout and the PARITY state depend on UART_RX_PARITY_EN.
package uart_pkg;

  localparam logic [13:0] TMR_MAX_DEF  = 14'd10416;
  localparam logic [13:0] HALF_MAX_DEF = 14'd5207;
  localparam int          DATA_BITS    = 8;

`ifdef UART_RX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3
`ifdef UART_RX_PARITY_EN
    , ST_PARITY = 3'd4
`endif
  } uart_state_e;

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period counter 0..TMR_MAX; wrap marks a bit boundary, half marks the half-bit point.
module uart_bit_timer
  import uart_pkg::*;
#(
  parameter logic [13:0] TMR_MAX  = TMR_MAX_DEF,
  parameter logic [13:0] HALF_MAX = HALF_MAX_DEF
) (
  input  logic CLK,
  input  logic RST,
  input  logic clr,
  output logic wrap,
  output logic half
);

  logic [13:0] cnt;

  assign wrap = (cnt == TMR_MAX);
  assign half = (cnt == HALF_MAX);

  always_ff @(posedge CLK) begin
    if (RST || clr || wrap) cnt <= '0;
    else                    cnt <= cnt + 14'd1;
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receiver, 8N1 by default; defining UART_RX_PARITY_EN adds one even-parity bit.
// Start bit is re-centred at half-bit so every later timer wrap lands mid-bit.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter logic [13:0] TMR_MAX  = TMR_MAX_DEF,
  parameter logic [13:0] HALF_MAX = HALF_MAX_DEF,
  parameter logic [3:0]  IDX_MAX  = 4'd8
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 UART_RX,
  output logic [DATA_BITS-1:0] recv_data,
  output logic                 recv_valid,
  output logic                 busy,
  output logic                 frame_err,
  output logic                 parity_err
);

  uart_state_e          state, state_n;
  logic                 rx_meta, rx_s;
  logic                 tmr_clr, wrap, half;
  logic [3:0]           idx;
  logic [DATA_BITS-1:0] sh;
  logic                 good_n, ferr_n;

  uart_bit_timer #(.TMR_MAX(TMR_MAX), .HALF_MAX(HALF_MAX)) u_tmr (
    .CLK (CLK),
    .RST (RST),
    .clr (tmr_clr),
    .wrap(wrap),
    .half(half)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= UART_RX;
      rx_s    <= rx_meta;
    end
  end

  assign busy = (state != ST_IDLE);

`ifdef UART_RX_PARITY_EN
  logic par_ok, perr_n;

  always_ff @(posedge CLK) begin
    if (RST) begin
      par_ok     <= 1'b1;
      parity_err <= 1'b0;
    end else begin
      // Even parity: data bits plus parity bit must XOR to zero.
      if (state == ST_PARITY && wrap) par_ok <= ~(^{sh, rx_s});
      parity_err <= perr_n;
    end
  end
`else
  assign parity_err = 1'b0;
`endif

  always_comb begin
    state_n = state;
    tmr_clr = 1'b0;
    good_n  = 1'b0;
    ferr_n  = 1'b0;
`ifdef UART_RX_PARITY_EN
    perr_n  = 1'b0;
`endif
    case (state)
      ST_IDLE: begin
        tmr_clr = 1'b1;
        if (!rx_s) state_n = ST_START;
      end
      ST_START: begin
        if (half) begin
          tmr_clr = 1'b1;
          state_n = rx_s ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (wrap && idx == IDX_MAX - 4'd1) begin
`ifdef UART_RX_PARITY_EN
          state_n = ST_PARITY;
`else
          state_n = ST_STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (wrap) state_n = ST_STOP;
      end
`endif
      ST_STOP: begin
        if (wrap) begin
          state_n = ST_IDLE;
          ferr_n  = ~rx_s;
`ifdef UART_RX_PARITY_EN
          perr_n  = ~par_ok;
          good_n  = rx_s & par_ok;
`else
          good_n  = rx_s;
`endif
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) state <= ST_IDLE;
    else     state <= state_n;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      idx        <= '0;
      sh         <= '0;
      recv_data  <= '0;
      recv_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      recv_valid <= good_n;
      frame_err  <= ferr_n;
      if (good_n) recv_data <= sh;
      if (state == ST_IDLE) begin
        idx <= '0;
      end else if (state == ST_DATA && wrap) begin
        sh[idx[2:0]] <= rx_s;
        idx          <= idx + 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Randomized scoreboard bench for uart_rx_ctrl at a shortened 64-cycle bit period.
// Also builds with UART_RX_PARITY_EN to cover the parity frame.
module tb_uart_rx_ctrl;

  localparam int BIT = 64;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       UART_RX = 1'b1;
  logic [7:0] recv_data;
  logic       recv_valid, busy, frame_err, parity_err;

  uart_rx_ctrl #(.TMR_MAX(14'd63), .HALF_MAX(14'd31), .IDX_MAX(4'd8)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .UART_RX   (UART_RX),
    .recv_data (recv_data),
    .recv_valid(recv_valid),
    .busy      (busy),
    .frame_err (frame_err),
    .parity_err(parity_err)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic       v;
    logic       fe;
    logic       pe;
    logic [7:0] d;
  } ev_t;

  ev_t        exp_q[$];
  int         total = 0;
  int         bad = 0;
  logic [7:0] last_good = 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Monitor: every output pulse must match the oldest expected event.
  always @(negedge CLK) begin : monitor
    ev_t e;
    if (recv_valid || frame_err || parity_err) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected pulse: v=%b fe=%b pe=%b data=%h", recv_valid, frame_err,
                 parity_err, recv_data);
      end else begin
        e = exp_q.pop_front();
        chk("pulse flags {v,fe,pe}", {29'd0, recv_valid, frame_err, parity_err},
            {29'd0, e.v, e.fe, e.pe});
        chk("recv_data", {24'd0, recv_data}, {24'd0, e.d});
      end
    end
  end

  // Holds the line at v for n cycles; pulses RST on cycle rst_at (-1 = never).
  task automatic drive(input logic v, input int n, input int rst_at);
    UART_RX = v;
    for (int c = 0; c < n; c++) begin
      RST = (c == rst_at);
      @(posedge CLK);
      #1;
    end
    RST = 1'b0;
  endtask

  // Sends one frame; the reference event is pushed before the line is driven.
  task automatic send(input logic [7:0] d, input logic stop, input logic par_bad,
                      input int rst_bit, input logic expect_ev);
    ev_t  e;
    logic ok_par;
`ifdef UART_RX_PARITY_EN
    ok_par = ~par_bad;
`else
    ok_par = 1'b1;
`endif
    if (expect_ev) begin
      e.v  = stop && ok_par;
      e.fe = !stop;
      e.pe = !ok_par;
      e.d  = e.v ? d : last_good;
      exp_q.push_back(e);
      if (e.v) last_good = d;
    end
    drive(1'b0, BIT, -1);
    for (int i = 0; i < 8; i++) drive(d[i], BIT, (i == rst_bit) ? 10 : -1);
`ifdef UART_RX_PARITY_EN
    drive((^d) ^ par_bad, BIT, -1);
`endif
    if (stop) begin
      drive(1'b1, BIT, -1);
    end else begin
      // Low stop bit long enough to be sampled, then a clean idle recovery.
      drive(1'b0, 40, -1);
      drive(1'b1, 3 * BIT, -1);
    end
  endtask

  initial begin
    logic [7:0] d;
    logic       stop, pbad;
    int         n;

    RST = 1'b1;
    UART_RX = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    chk("reset recv_data", {24'd0, recv_data}, 32'd0);
    chk("reset recv_valid", {31'd0, recv_valid}, 32'd0);
    chk("reset frame_err", {31'd0, frame_err}, 32'd0);
    chk("reset parity_err", {31'd0, parity_err}, 32'd0);
    chk("reset busy", {31'd0, busy}, 32'd0);
    RST = 1'b0;
    drive(1'b1, BIT, -1);

    send(8'h55, 1'b1, 1'b0, -1, 1'b1);
    drive(1'b1, BIT, -1);

    // Back-to-back frames with no idle gap.
    send(8'hA3, 1'b1, 1'b0, -1, 1'b1);
    send(8'h0F, 1'b1, 1'b0, -1, 1'b1);
    drive(1'b1, BIT, -1);

    // Short low glitch must be rejected at the half-bit check.
    drive(1'b0, 18, -1);
    chk("glitch busy raised", {31'd0, busy}, 32'd1);
    UART_RX = 1'b1;
    n = 0;
    while (busy && n < 200) begin
      @(posedge CLK);
      #1;
      n++;
    end
    chk("glitch busy cleared", {31'd0, busy}, 32'd0);
    chk("glitch release in time", {31'd0, (n <= 40)}, 32'd1);
    drive(1'b1, BIT, -1);

    send(8'h3C, 1'b0, 1'b0, -1, 1'b1);

    // Reset during data bit 4 abandons the frame and clears recv_data.
    send(8'hFF, 1'b1, 1'b0, 4, 1'b0);
    last_good = 8'h00;
    chk("after mid-frame reset data", {24'd0, recv_data}, 32'd0);
    drive(1'b1, 2 * BIT, -1);
    send(8'h81, 1'b1, 1'b0, -1, 1'b1);
    drive(1'b1, BIT, -1);

`ifdef UART_RX_PARITY_EN
    send(8'h07, 1'b1, 1'b1, -1, 1'b1);
    send(8'h07, 1'b1, 1'b0, -1, 1'b1);
    send(8'hC5, 1'b0, 1'b1, -1, 1'b1);
    drive(1'b1, BIT, -1);
`endif

    for (int k = 0; k < 20; k++) begin
      d    = 8'($urandom);
      stop = ($urandom_range(0, 3) != 0);
`ifdef UART_RX_PARITY_EN
      pbad = ($urandom_range(0, 3) == 0);
`else
      pbad = 1'b0;
`endif
      send(d, stop, pbad, -1, 1'b1);
      n = $urandom_range(0, 2);
      if (n > 0) drive(1'b1, n * BIT, -1);
    end

    drive(1'b1, 2 * BIT, -1);
    chk("scoreboard drained", exp_q.size(), 32'd0);
    chk("final busy", {31'd0, busy}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
